// File: rtl/peripheral_gpio_debounce.sv
// GPIO input conditioning: per-bit pad synchronizer, optional tick-based debounce filter,
// and registered one-cycle rise/fall event pulses for the interrupt logic.
module peripheral_gpio_debounce #(
   parameter int unsigned PDATA_SIZE     = 32,
   parameter int unsigned SYNC_DEPTH     = 3,
   parameter int unsigned DEBOUNCE_WIDTH = 16,
   parameter int unsigned PRESCALE_WIDTH = 16
) (
   input  logic                      PCLK,
   input  logic                      PRESET,
   input  logic [PDATA_SIZE-1:0]     gpio_pad_i,
   input  logic [PDATA_SIZE-1:0]     debounce_en_i,
   input  logic [DEBOUNCE_WIDTH-1:0] debounce_limit_i,
   input  logic [PRESCALE_WIDTH-1:0] prescale_i,
   output logic [PDATA_SIZE-1:0]     gpio_o,
   output logic [PDATA_SIZE-1:0]     rise_o,
   output logic [PDATA_SIZE-1:0]     fall_o
);

   // Synchronizer chain: stage 0 samples the pad, stage SYNC_DEPTH-1 is the only consumer.
   logic [SYNC_DEPTH-1:0][PDATA_SIZE-1:0] sync_q, sync_d;
   logic [PDATA_SIZE-1:0]                 sync_s;

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = gpio_pad_i;
      for (int unsigned k = 1; k < SYNC_DEPTH; k++) begin
         sync_d[k] = sync_q[k-1];
      end
   end

   assign sync_s = sync_q[SYNC_DEPTH-1];

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   // Shared prescaler; the >= compare lets a lowered prescale_i take effect without a wrap.
   logic [PRESCALE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
   logic                      tick;

   always_comb begin
      tick      = (pre_cnt_q >= prescale_i);
      pre_cnt_d = tick ? '0 : pre_cnt_q + PRESCALE_WIDTH'(1);
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         pre_cnt_q <= '0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
      end
   end

   // Per-bit filter state: accepted level and count of consecutive disagreeing ticks.
   logic [PDATA_SIZE-1:0]                     level_q, level_d;
   logic [PDATA_SIZE-1:0][DEBOUNCE_WIDTH-1:0] cnt_q, cnt_d;
   logic [PDATA_SIZE-1:0]                     rise_q, rise_d;
   logic [PDATA_SIZE-1:0]                     fall_q, fall_d;

   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      for (int unsigned i = 0; i < PDATA_SIZE; i++) begin
         if (!debounce_en_i[i]) begin
            level_d[i] = sync_s[i];
            cnt_d[i]   = '0;
         end else if (sync_s[i] == level_q[i]) begin
            // Disagreement ended before acceptance: discard the partial count.
            cnt_d[i] = '0;
         end else if (tick) begin
            if (cnt_q[i] >= debounce_limit_i) begin
               level_d[i] = sync_s[i];
               cnt_d[i]   = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + DEBOUNCE_WIDTH'(1);
            end
         end
      end
      rise_d = level_d & ~level_q;
      fall_d = ~level_d & level_q;
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         level_q <= '0;
         cnt_q   <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
      end else begin
         level_q <= level_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign gpio_o = level_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: tb/tb_peripheral_gpio_debounce.sv
// Bench for peripheral_gpio_debounce: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural model.
module tb_peripheral_gpio_debounce;

   localparam int unsigned NB  = 32;
   localparam int unsigned SD  = 3;
   localparam int unsigned DW  = 16;
   localparam int unsigned PW  = 16;

   logic          PCLK;
   logic          PRESET;
   logic [NB-1:0] gpio_pad_i;
   logic [NB-1:0] debounce_en_i;
   logic [DW-1:0] debounce_limit_i;
   logic [PW-1:0] prescale_i;
   logic [NB-1:0] gpio_o;
   logic [NB-1:0] rise_o;
   logic [NB-1:0] fall_o;

   peripheral_gpio_debounce #(
      .PDATA_SIZE    (NB),
      .SYNC_DEPTH    (SD),
      .DEBOUNCE_WIDTH(DW),
      .PRESCALE_WIDTH(PW)
   ) dut (
      .PCLK            (PCLK),
      .PRESET          (PRESET),
      .gpio_pad_i      (gpio_pad_i),
      .debounce_en_i   (debounce_en_i),
      .debounce_limit_i(debounce_limit_i),
      .prescale_i      (prescale_i),
      .gpio_o          (gpio_o),
      .rise_o          (rise_o),
      .fall_o          (fall_o)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   int n_vec = 0;
   int n_err = 0;

   // Model: pad history queue (index j = pad value captured j edges ago), cycles since the
   // last tick, and per bit the number of ticks the synchronized input has disagreed.
   logic [NB-1:0] hist[$];
   int            since_tick;
   int            ticks_dis[NB];
   logic [NB-1:0] q_m, rise_m, fall_m;

   task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      for (int j = 0; j < int'(SD); j++) hist.push_back('0);
      since_tick = 0;
      for (int i = 0; i < int'(NB); i++) ticks_dis[i] = 0;
      q_m    = '0;
      rise_m = '0;
      fall_m = '0;
   endtask

   task automatic model_update();
      logic [NB-1:0] s;
      logic [NB-1:0] q_new;
      bit            tick;
      s     = hist[SD-1];
      tick  = (since_tick >= int'(prescale_i));
      since_tick = tick ? 0 : since_tick + 1;
      q_new = q_m;
      for (int i = 0; i < int'(NB); i++) begin
         if (!debounce_en_i[i]) begin
            q_new[i]     = s[i];
            ticks_dis[i] = 0;
         end else if (s[i] == q_m[i]) begin
            ticks_dis[i] = 0;
         end else if (tick) begin
            // This tick is disagreement tick number ticks_dis+1; accepted once it exceeds limit.
            if (ticks_dis[i] + 1 > int'(debounce_limit_i)) begin
               q_new[i]     = s[i];
               ticks_dis[i] = 0;
            end else begin
               ticks_dis[i] = ticks_dis[i] + 1;
            end
         end
      end
      rise_m = q_new & ~q_m;
      fall_m = ~q_new & q_m;
      q_m    = q_new;
      hist.push_front(gpio_pad_i);
      void'(hist.pop_back());
   endtask

   task automatic step();
      @(posedge PCLK);
      if (!PRESET) model_update();
      #1;
      check("gpio_o", gpio_o, q_m);
      check("rise_o", rise_o, rise_m);
      check("fall_o", fall_o, fall_m);
   endtask

   task automatic do_reset();
      #2;
      PRESET = 1'b1;
      model_reset();
      #1;
      check("rst_gpio", gpio_o, '0);
      check("rst_rise", rise_o, '0);
      check("rst_fall", fall_o, '0);
      repeat (2) step();
      @(negedge PCLK);
      PRESET = 1'b0;
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      int  d;
      bit  found;
      PRESET           = 1'b1;
      gpio_pad_i       = '0;
      debounce_en_i    = '0;
      debounce_limit_i = '0;
      prescale_i       = '0;
      model_reset();
      do_reset();

      // 1: sync-only path, rise after edge 4, then a single fall pulse.
      gpio_pad_i = 32'h1;
      steps(3);
      check("t1_gpio_e3", gpio_o, 32'h0);
      step();
      check("t1_gpio_e4", gpio_o, 32'h1);
      check("t1_rise_e4", rise_o, 32'h1);
      step();
      check("t1_rise_e5", rise_o, 32'h0);
      gpio_pad_i = 32'h0;
      steps(4);
      check("t1_fall", fall_o, 32'h1);
      step();
      check("t1_fall_end", fall_o, 32'h0);

      // 2: short pulse rejected, held level accepted after edge 8.
      do_reset();
      debounce_en_i    = 32'h8;
      debounce_limit_i = 16'd4;
      prescale_i       = 16'd0;
      gpio_pad_i       = 32'h8;
      steps(4);
      gpio_pad_i = 32'h0;
      steps(10);
      check("t2_glitch", gpio_o, 32'h0);
      gpio_pad_i = 32'h8;
      steps(7);
      check("t2_gpio_e7", gpio_o, 32'h0);
      step();
      check("t2_gpio_e8", gpio_o, 32'h8);
      check("t2_rise_e8", rise_o, 32'h8);

      // 3: prescaled acceptance lands 21..30 cycles after the synchronized change.
      do_reset();
      debounce_en_i    = 32'h20;
      debounce_limit_i = 16'd2;
      prescale_i       = 16'd9;
      gpio_pad_i       = 32'h20;
      steps(3);
      found = 1'b0;
      d     = 0;
      for (int k = 1; k <= 40 && !found; k++) begin
         step();
         d = k;
         if (gpio_o[5]) found = 1'b1;
      end
      check("t3_window", {31'd0, found && d >= 21 && d <= 30}, 32'h1);

      // 4: mixed enables, two groups rise on different edges.
      do_reset();
      debounce_en_i    = 32'h0000FFFF;
      debounce_limit_i = 16'd3;
      prescale_i       = 16'd0;
      gpio_pad_i       = 32'hFFFFFFFF;
      steps(4);
      check("t4_rise_e4", rise_o, 32'hFFFF0000);
      check("t4_gpio_e4", gpio_o, 32'hFFFF0000);
      steps(2);
      check("t4_rise_e6", rise_o, 32'h0);
      step();
      check("t4_rise_e7", rise_o, 32'h0000FFFF);
      check("t4_gpio_e7", gpio_o, 32'hFFFFFFFF);
      step();
      check("t4_rise_e8", rise_o, 32'h0);

      // 5: reset mid-count restarts the full delay.
      do_reset();
      debounce_en_i    = 32'h1;
      debounce_limit_i = 16'd4;
      gpio_pad_i       = 32'h1;
      steps(6);
      do_reset();
      steps(7);
      check("t5_gpio_e7", gpio_o, 32'h0);
      step();
      check("t5_gpio_e8", gpio_o, 32'h1);
      check("t5_rise_e8", rise_o, 32'h1);

      // 6: lowering the limit below the running count accepts on the next tick.
      do_reset();
      debounce_en_i    = 32'h1;
      debounce_limit_i = 16'd10;
      gpio_pad_i       = 32'h1;
      steps(8);
      check("t6_gpio_pre", gpio_o, 32'h0);
      debounce_limit_i = 16'd2;
      step();
      check("t6_gpio_post", gpio_o, 32'h1);

      // Randomized run against the model.
      do_reset();
      debounce_en_i    = $urandom;
      debounce_limit_i = 16'($urandom_range(0, 5));
      prescale_i       = 16'($urandom_range(0, 3));
      for (int n = 0; n < 3000; n++) begin
         gpio_pad_i = gpio_pad_i ^ ($urandom & $urandom & $urandom & $urandom);
         if ($urandom_range(0, 49) == 0) debounce_en_i = $urandom;
         if ($urandom_range(0, 39) == 0) debounce_limit_i = 16'($urandom_range(0, 5));
         if ($urandom_range(0, 39) == 0) prescale_i = 16'($urandom_range(0, 3));
         if ($urandom_range(0, 299) == 0) do_reset();
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
